// File: rtl/tl_pkg.sv
// tl_pkg: shared definitions for the traffic-light lamp sequencer.
//   - phase codes as captured by the controller's state register
//   - lamp bit indices and lamp patterns, bit order {left, green, yellow, red}
//   - sequencer state encoding
//   - helpers mapping a requested code / displayed phase to lamp patterns
package tl_pkg;

    localparam logic [2:0] PH_ALL_RED    = 3'd0;
    localparam logic [2:0] PH_A_STRAIGHT = 3'd1;
    localparam logic [2:0] PH_A_LEFT     = 3'd2;
    localparam logic [2:0] PH_B_STRAIGHT = 3'd3;
    localparam logic [2:0] PH_B_LEFT     = 3'd4;
    localparam logic [2:0] PH_FLASH      = 3'd5;

    localparam int LAMP_RED    = 0;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_GREEN  = 2;
    localparam int LAMP_LEFT   = 3;

    localparam logic [3:0] L_DARK   = 4'b0000;
    localparam logic [3:0] L_RED    = 4'b0001 << LAMP_RED;
    localparam logic [3:0] L_YELLOW = 4'b0001 << LAMP_YELLOW;
    localparam logic [3:0] L_GREEN  = 4'b0001 << LAMP_GREEN;
    // A protected left arrow is shown together with the red ball.
    localparam logic [3:0] L_LEFT   = (4'b0001 << LAMP_LEFT) | L_RED;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } lamp_pair_t;

    // Codes 110/111 are not phases; they fall back to the safe all-red phase.
    function automatic logic [2:0] map_phase(input logic [2:0] code);
        return (code > PH_FLASH) ? PH_ALL_RED : code;
    endfunction

    function automatic lamp_pair_t hold_lamps(input logic [2:0] phase, input logic flash);
        lamp_pair_t lp;
        lp = '{a: L_RED, b: L_RED};
        case (phase)
            PH_A_STRAIGHT: lp = '{a: L_GREEN, b: L_RED};
            PH_A_LEFT:     lp = '{a: L_LEFT,  b: L_RED};
            PH_B_STRAIGHT: lp = '{a: L_RED,   b: L_GREEN};
            PH_B_LEFT:     lp = '{a: L_RED,   b: L_LEFT};
            PH_FLASH: begin
                if (flash) lp = '{a: L_YELLOW, b: L_YELLOW};
                else       lp = '{a: L_DARK,   b: L_DARK};
            end
            default:       lp = '{a: L_RED,   b: L_RED};
        endcase
        return lp;
    endfunction

    // A road that currently has right-of-way goes yellow; a stopped road stays red.
    function automatic logic [3:0] clearing(input logic [3:0] l);
        return (l[LAMP_LEFT] || l[LAMP_GREEN]) ? L_YELLOW : L_RED;
    endfunction

    function automatic lamp_pair_t phase_lamps(input state_t st, input logic [2:0] phase,
                                               input logic flash);
        lamp_pair_t lp;
        lp = hold_lamps(phase, flash);
        case (st)
            ST_YELLOW: begin
                lp.a = clearing(lp.a);
                lp.b = clearing(lp.b);
            end
            ST_ALLRED: lp = '{a: L_RED, b: L_RED};
            default:   ;
        endcase
        return lp;
    endfunction

endpackage

// File: rtl/tl_tick_counter.sv
// tl_tick_counter: CW-bit interval counter advanced by the tick enable.
//   clk, reset (async, active-low)
//   clr    : synchronous clear, wins over en
//   en     : count enable (already qualified with tick by the user)
//   tc_val : terminal count to compare against
//   tc     : count == tc_val; the counter wraps to zero on an enabled tc
module tl_tick_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] tc_val,
    output logic          tc
);

    logic [CW-1:0] count;

    assign tc = (count == tc_val);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tl_lamp_sequencer.sv
// tl_lamp_sequencer: applies requested traffic-light phases to the lamps,
// inserting a timed yellow and all-red clearance on every phase change.
//   clk, reset (async, active-low)
//   tick       : timebase enable; all intervals are counted in ticks
//   phase_req  : level request, held with phase_code stable until phase_ack
//   phase_code : requested phase (110/111 treated as all red)
//   phase_ack  : one-cycle pulse when the requested phase is on the lamps
//   busy       : high during yellow and all-red clearance
//   cur_phase  : phase currently displayed
//   lamp_a/b   : road lamps {left, green, yellow, red}
module tl_lamp_sequencer
    import tl_pkg::*;
#(
    parameter int YEL_TICKS    = 3,
    parameter int ALLRED_TICKS = 1,
    parameter int FLASH_TICKS  = 2,
    parameter int CW           = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       phase_req,
    input  logic [2:0] phase_code,
    output logic       phase_ack,
    output logic       busy,
    output logic [2:0] cur_phase,
    output logic [3:0] lamp_a,
    output logic [3:0] lamp_b
);

    localparam logic [CW-1:0] YEL_TC    = CW'(YEL_TICKS - 1);
    localparam logic [CW-1:0] ALLRED_TC = CW'(ALLRED_TICKS - 1);
    localparam logic [CW-1:0] FLASH_TC  = CW'(FLASH_TICKS - 1);

    state_t     state_q, state_d;
    logic [2:0] pending_q, pending_d;
    logic [2:0] cur_d;
    logic [2:0] req_code;
    logic       flash_q, flash_d;
    logic       ack_d;
    logic       cnt_clr, cnt_en, cnt_tc;
    logic [CW-1:0] cnt_tc_val;
    lamp_pair_t lamps_d;

    // One counter serves yellow, all-red and the flash half-period; which
    // terminal count applies follows from the current state.
    always_comb begin
        case (state_q)
            ST_YELLOW: cnt_tc_val = YEL_TC;
            ST_ALLRED: cnt_tc_val = ALLRED_TC;
            default:   cnt_tc_val = FLASH_TC;
        endcase
    end

    assign cnt_en = tick && ((state_q != ST_HOLD) || (cur_phase == PH_FLASH));

    tl_tick_counter #(.CW(CW)) u_tick_counter (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (cnt_tc_val),
        .tc     (cnt_tc)
    );

    assign req_code = map_phase(phase_code);

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_phase;
        pending_d = pending_q;
        flash_d   = flash_q;
        ack_d     = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if ((cur_phase == PH_FLASH) && tick && cnt_tc) flash_d = ~flash_q;
                // The ack cycle itself is skipped so a still-high req cannot re-trigger.
                if (phase_req && !phase_ack) begin
                    if (req_code == cur_phase) begin
                        ack_d = 1'b1;
                    end else begin
                        pending_d = req_code;
                        cnt_clr   = 1'b1;
                        if (cur_phase == PH_ALL_RED) begin
                            // Nothing to clear from all red: apply at once.
                            cur_d   = req_code;
                            ack_d   = 1'b1;
                            flash_d = 1'b1;
                        end else if (cur_phase == PH_FLASH) begin
                            state_d = ST_ALLRED;
                        end else begin
                            state_d = ST_YELLOW;
                        end
                    end
                end
            end
            ST_YELLOW: begin
                if (tick && cnt_tc) state_d = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (tick && cnt_tc) begin
                    state_d = ST_HOLD;
                    cur_d   = pending_q;
                    ack_d   = 1'b1;
                    flash_d = 1'b1;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Lamps are registered from next-state values so they change on the same
    // edge as the state and can never glitch through an unsafe combination.
    assign lamps_d = phase_lamps(state_d, cur_d, flash_d);

    // NOTE: reset puts every register, outputs included, in a known safe
    // value, so an async reset forces all-red immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HOLD;
            cur_phase <= PH_ALL_RED;
            pending_q <= PH_ALL_RED;
            flash_q   <= 1'b1;
            phase_ack <= 1'b0;
            busy      <= 1'b0;
            lamp_a    <= L_RED;
            lamp_b    <= L_RED;
        end else begin
            state_q   <= state_d;
            cur_phase <= cur_d;
            pending_q <= pending_d;
            flash_q   <= flash_d;
            phase_ack <= ack_d;
            busy      <= (state_d != ST_HOLD);
            lamp_a    <= lamps_d.a;
            lamp_b    <= lamps_d.b;
        end
    end

endmodule

// File: tb/tb_tl_lamp_sequencer.sv
// tb_tl_lamp_sequencer: randomized and directed stimulus for tl_lamp_sequencer,
// checked every cycle against a transaction-level model that tracks the
// displayed phase and the number of ticks elapsed in a transition.
module tb_tl_lamp_sequencer;

    localparam int YEL = 3;
    localparam int AR  = 1;
    localparam int FL  = 2;
    localparam int CW  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       phase_req = 1'b0;
    logic [2:0] phase_code = 3'd0;
    logic       phase_ack;
    logic       busy;
    logic [2:0] cur_phase;
    logic [3:0] lamp_a;
    logic [3:0] lamp_b;

    tl_lamp_sequencer #(
        .YEL_TICKS    (YEL),
        .ALLRED_TICKS (AR),
        .FLASH_TICKS  (FL),
        .CW           (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .phase_req  (phase_req),
        .phase_code (phase_code),
        .phase_ack  (phase_ack),
        .busy       (busy),
        .cur_phase  (cur_phase),
        .lamp_a     (lamp_a),
        .lamp_b     (lamp_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_phase;        // displayed phase
    bit m_trans;        // a transition is in progress
    int m_target;       // phase to apply when it ends
    int m_yel;          // yellow ticks for this transition (0 out of flashing)
    int m_ticks;        // ticks elapsed in this transition
    int m_flash_ticks;  // ticks spent holding the flashing phase
    bit m_ack;          // ack expected in the current cycle

    int tick_mode;      // 1: tick every 4 clocks, 0: random
    int cyc = 0;

    function automatic logic [7:0] hold_of(input int ph, input bit fl);
        case (ph)
            1:       return 8'h41;
            2:       return 8'h91;
            3:       return 8'h14;
            4:       return 8'h19;
            5:       return fl ? 8'h22 : 8'h00;
            default: return 8'h11;
        endcase
    endfunction

    function automatic logic [3:0] clear_of(input logic [3:0] l);
        return (l[3] | l[2]) ? 4'b0010 : 4'b0001;
    endfunction

    function automatic logic [7:0] exp_lamps();
        logic [7:0] h;
        if (m_trans) begin
            h = hold_of(m_phase, 1'b1);
            if (m_ticks < m_yel) return {clear_of(h[7:4]), clear_of(h[3:0])};
            return 8'h11;
        end
        return hold_of(m_phase, ((m_flash_ticks / FL) % 2) == 0);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_trans = 0; m_target = 0; m_yel = 0;
        m_ticks = 0; m_flash_ticks = 0; m_ack = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        bit ack_prev;
        int t;
        if (!reset) begin
            model_reset();
            return;
        end
        ack_prev = m_ack;
        m_ack = 0;
        if (m_trans) begin
            if (tick) begin
                m_ticks++;
                if (m_ticks == m_yel + AR) begin
                    m_phase = m_target;
                    m_trans = 0;
                    m_ack = 1;
                    m_flash_ticks = 0;
                end
            end
        end else begin
            if (m_phase == 5 && tick) m_flash_ticks++;
            if (phase_req && !ack_prev) begin
                t = (phase_code > 3'd5) ? 0 : int'(phase_code);
                if (t == m_phase) begin
                    m_ack = 1;
                end else if (m_phase == 0) begin
                    m_phase = t;
                    m_ack = 1;
                    m_flash_ticks = 0;
                end else begin
                    m_trans = 1;
                    m_target = t;
                    m_ticks = 0;
                    m_yel = (m_phase == 5) ? 0 : YEL;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e;
        e = exp_lamps();
        check("ack", phase_ack, m_ack);
        check("busy", busy, m_trans);
        check("cur_phase", cur_phase, m_phase);
        check("lamp_a", lamp_a, e[7:4]);
        check("lamp_b", lamp_b, e[3:0]);
        check("no_dual_green", (lamp_a[3] | lamp_a[2]) & (lamp_b[3] | lamp_b[2]), 0);
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // then the next inputs are driven.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        cyc++;
        if (m_ack) phase_req = 1'b0;
        tick = (tick_mode == 1) ? ((cyc % 4) == 0) : ($urandom_range(0, 2) == 0);
    endtask

    task automatic idle(input int n);
        phase_req = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic request(input logic [2:0] code, output int lat);
        phase_code = code;
        phase_req = 1'b1;
        lat = 0;
        do begin
            cycle();
            lat++;
        end while (!m_ack && lat < 400);
        check("ack_within_budget", phase_ack, 1);
    endtask

    int lat;
    int n;

    initial begin
        model_reset();
        tick_mode = 1;
        repeat (2) @(negedge clk);
        check("rst_lamp_a", lamp_a, 4'b0001);
        check("rst_lamp_b", lamp_b, 4'b0001);
        check("rst_cur_phase", cur_phase, 3'd0);
        check("rst_ack", phase_ack, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;

        // 000 -> 001 applies directly
        request(3'd1, lat);
        check("lat_0_to_1", lat, 1);
        // 001 -> 011 full yellow + all-red
        request(3'd3, lat);
        // 011 -> 010, then into flashing and out again via all-red only
        request(3'd2, lat);
        request(3'd5, lat);
        idle(20);
        request(3'd0, lat);

        // Code change mid-yellow is ignored
        request(3'd1, lat);
        phase_code = 3'd3;
        phase_req = 1'b1;
        repeat (3) cycle();
        phase_code = 3'd4;
        n = 0;
        while (!m_ack && n < 400) begin
            cycle();
            n++;
        end
        check("pending_kept", cur_phase, 3'd3);
        idle(1);
        request(3'd4, lat);

        // Illegal code and same-code requests
        request(3'd0, lat);
        request(3'd1, lat);
        request(3'd7, lat);
        check("illegal_maps_to_0", cur_phase, 3'd0);
        request(3'd1, lat);
        idle(1);
        request(3'd1, lat);
        check("lat_same_code", lat, 1);
        check("same_code_lamp_a", lamp_a, 4'b0100);

        // Async reset in the middle of all-red
        phase_code = 3'd3;
        phase_req = 1'b1;
        n = 0;
        while (!(m_trans && m_ticks >= m_yel) && n < 400) begin
            cycle();
            n++;
        end
        check("reached_allred", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_lamp_a", lamp_a, 4'b0001);
        check("async_rst_lamp_b", lamp_b, 4'b0001);
        check("async_rst_cur_phase", cur_phase, 3'd0);
        check("async_rst_busy", busy, 0);
        model_reset();
        phase_req = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        idle(2);

        // Randomized requests and tick pattern
        tick_mode = 0;
        for (int i = 0; i < 120; i++) begin
            request(3'($urandom_range(0, 7)), lat);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
